// File: rtl/hazard_stall_controller_if.sv
// Decode-stage hazard bus: pipeline status in, stage enables/flushes out.
// master = pipeline side, slave = hazard_stall_controller.
interface hazard_stall_controller_if;
  logic [6:0] if_id_opcode;
  logic [4:0] if_id_rs1;
  logic [4:0] if_id_rs2;
  logic [4:0] id_ex_rd;
  logic       id_ex_memread;
  logic [4:0] ex_mem_rd;
  logic       ex_mem_memread;
  logic       ex_mem_memwrite;
  logic       mem_ready;
  logic       branch_taken;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       back_freeze;

  modport master (
    output if_id_opcode, if_id_rs1, if_id_rs2, id_ex_rd, id_ex_memread,
           ex_mem_rd, ex_mem_memread, ex_mem_memwrite, mem_ready, branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, back_freeze
  );

  modport slave (
    input  if_id_opcode, if_id_rs1, if_id_rs2, id_ex_rd, id_ex_memread,
           ex_mem_rd, ex_mem_memread, ex_mem_memwrite, mem_ready, branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, back_freeze
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use / branch-operand stalls, control-transfer flushes and memory-wait freeze.
// Optional saturating performance counters when PERF_COUNTERS_EN is defined.
module hazard_stall_controller
`ifdef PERF_COUNTERS_EN
  #(parameter int unsigned CNT_WIDTH = 32)
`endif
(
  input logic clk,
  input logic rst,
  hazard_stall_controller_if.slave hz
`ifdef PERF_COUNTERS_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count,
  output logic [CNT_WIDTH-1:0] memwait_cycles
`endif
);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StStall   = 2'd1;
  localparam logic [1:0] StMemWait = 2'd2;

  localparam logic [6:0] OpSw  = 7'h6b;
  localparam logic [6:0] OpBeq = 7'h44;
  localparam logic [6:0] OpBne = 7'h45;
  localparam logic [6:0] OpBlt = 7'h50;
  localparam logic [6:0] OpBge = 7'h51;
  localparam logic [6:0] OpJ   = 7'h42;
  localparam logic [6:0] OpJal = 7'h43;
  localparam logic [6:0] OpJr  = 7'h08;

  logic [1:0] state_q, state_d;
  logic       ret_stall_q, ret_stall_d;

  logic is_j, is_jal, is_jr, is_branch, is_sw, is_rfmt;
  logic uses_rs1, uses_rs2, ctrl_dep;
  logic match_ex, match_mem;
  logic stall_any, stall_two, ctrl_xfer, mem_busy;
  logic want_freeze, want_stall, want_flush;

  always_comb begin
    is_j      = (hz.if_id_opcode == OpJ);
    is_jal    = (hz.if_id_opcode == OpJal);
    is_jr     = (hz.if_id_opcode == OpJr);
    is_sw     = (hz.if_id_opcode == OpSw);
    is_branch = (hz.if_id_opcode == OpBeq) || (hz.if_id_opcode == OpBne) ||
                (hz.if_id_opcode == OpBlt) || (hz.if_id_opcode == OpBge);
    // R-format ALU ops occupy the opcode space with bit 6 clear; jr is the one exception.
    is_rfmt   = !hz.if_id_opcode[6] && !is_jr;
    uses_rs1  = !(is_j || is_jal);
    uses_rs2  = is_rfmt || is_sw || is_branch;
    ctrl_dep  = is_branch || is_jr;

    match_ex  = (hz.id_ex_rd != 5'd0) &&
                ((uses_rs1 && (hz.if_id_rs1 == hz.id_ex_rd)) ||
                 (uses_rs2 && (hz.if_id_rs2 == hz.id_ex_rd)));
    match_mem = (hz.ex_mem_rd != 5'd0) &&
                ((uses_rs1 && (hz.if_id_rs1 == hz.ex_mem_rd)) ||
                 (uses_rs2 && (hz.if_id_rs2 == hz.ex_mem_rd)));

    stall_two = hz.id_ex_memread && match_ex && ctrl_dep;
    stall_any = (hz.id_ex_memread && match_ex) ||
                (hz.ex_mem_memread && match_mem && ctrl_dep);
    ctrl_xfer = is_j || is_jal || is_jr || (is_branch && hz.branch_taken);
    mem_busy  = (hz.ex_mem_memread || hz.ex_mem_memwrite) && !hz.mem_ready;
  end

  always_comb begin
    state_d     = state_q;
    ret_stall_d = ret_stall_q;
    want_freeze = 1'b0;
    want_stall  = 1'b0;
    want_flush  = 1'b0;
    case (state_q)
      StStall: begin
        if (mem_busy) begin
          // Pending stall cycle survives the freeze via the saved return state.
          want_freeze = 1'b1;
          state_d     = StMemWait;
          ret_stall_d = 1'b1;
        end else begin
          want_stall = 1'b1;
          state_d    = StRun;
        end
      end
      StMemWait: begin
        if (mem_busy) begin
          want_freeze = 1'b1;
        end else begin
          want_stall = stall_any;
          want_flush = !stall_any && ctrl_xfer;
          state_d    = ret_stall_q ? StStall : StRun;
        end
      end
      default: begin
        state_d = StRun;
        if (mem_busy) begin
          want_freeze = 1'b1;
          state_d     = StMemWait;
          ret_stall_d = 1'b0;
        end else if (stall_any) begin
          want_stall = 1'b1;
          if (stall_two) state_d = StStall;
        end else begin
          want_flush = ctrl_xfer;
        end
      end
    endcase
  end

  always_comb begin
    if (!rst) begin
      hz.pc_write    = 1'b0;
      hz.if_id_write = 1'b0;
      hz.if_id_flush = 1'b1;
      hz.id_ex_flush = 1'b1;
      hz.back_freeze = 1'b0;
    end else begin
      hz.pc_write    = !(want_freeze || want_stall);
      hz.if_id_write = !(want_freeze || want_stall);
      hz.if_id_flush = want_flush;
      hz.id_ex_flush = want_stall;
      hz.back_freeze = want_freeze;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      ret_stall_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_stall_q <= ret_stall_d;
    end
  end

`ifdef PERF_COUNTERS_EN
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles   <= '0;
      flush_count    <= '0;
      memwait_cycles <= '0;
    end else begin
      if (hz.id_ex_flush && !hz.back_freeze && (stall_cycles != CntMax))
        stall_cycles <= stall_cycles + CntOne;
      if (hz.if_id_flush && (flush_count != CntMax))
        flush_count <= flush_count + CntOne;
      if (hz.back_freeze && (memwait_cycles != CntMax))
        memwait_cycles <= memwait_cycles + CntOne;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller; counter checks only with PERF_COUNTERS_EN.
module tb_hazard_stall_controller;
  localparam logic [6:0] OpAdd = 7'h20;
  localparam logic [6:0] OpLw  = 7'h63;
  localparam logic [6:0] OpSw  = 7'h6b;
  localparam logic [6:0] OpBeq = 7'h44;
  localparam logic [6:0] OpBne = 7'h45;
  localparam logic [6:0] OpJ   = 7'h42;
  localparam logic [6:0] OpJal = 7'h43;
  localparam logic [6:0] OpJr  = 7'h08;

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, back_freeze}
  localparam logic [4:0] ONorm   = 5'b11000;
  localparam logic [4:0] OStall  = 5'b00010;
  localparam logic [4:0] OFlush  = 5'b11100;
  localparam logic [4:0] OFreeze = 5'b00001;
  localparam logic [4:0] ORst    = 5'b00110;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [4:0] outs;

  hazard_stall_controller_if hz ();

`ifdef PERF_COUNTERS_EN
  logic [31:0] stall_cycles, flush_count, memwait_cycles;
  hazard_stall_controller #(.CNT_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .hz             (hz),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count),
    .memwait_cycles (memwait_cycles)
  );
`else
  hazard_stall_controller dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );
`endif

  always #5 clk = ~clk;
  assign outs = {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_flush, hz.back_freeze};

  task automatic idle();
    hz.if_id_opcode    = 7'h00;
    hz.if_id_rs1       = 5'd0;
    hz.if_id_rs2       = 5'd0;
    hz.id_ex_rd        = 5'd0;
    hz.id_ex_memread   = 1'b0;
    hz.ex_mem_rd       = 5'd0;
    hz.ex_mem_memread  = 1'b0;
    hz.ex_mem_memwrite = 1'b0;
    hz.mem_ready       = 1'b1;
    hz.branch_taken    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic decode(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2);
    hz.if_id_opcode = op;
    hz.if_id_rs1    = r1;
    hz.if_id_rs2    = r2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    @(negedge clk);
    if (outs !== ORst) begin
      errors++; $display("FAIL reset_outs: got %b want %b", outs, ORst);
    end
    checks++;
`ifdef PERF_COUNTERS_EN
    if ({stall_cycles, flush_count, memwait_cycles} !== 96'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0",
                         stall_cycles, flush_count, memwait_cycles);
    end
    checks++;
`endif
    rst = 1'b1;
    tick();
    @(negedge clk);
    if (outs !== ONorm) begin
      errors++; $display("FAIL reset_release: got %b want %b", outs, ONorm);
    end
    checks++;
    tick();
  endtask

  task automatic test_load_use();
    logic [4:0] exp [7];
    exp = '{OStall, ONorm, OStall, ONorm, ONorm, OFlush, ONorm};
    for (int i = 0; i < 7; i++) begin
      idle();
      hz.id_ex_memread = 1'b1;
      hz.id_ex_rd      = 5'd5;
      case (i)
        0: decode(OpAdd, 5'd5, 5'd7);
        1: begin
          hz.id_ex_memread  = 1'b0;
          hz.id_ex_rd       = 5'd0;
          hz.ex_mem_memread = 1'b1;
          hz.ex_mem_rd      = 5'd5;
          decode(OpAdd, 5'd5, 5'd7);
        end
        2: decode(OpAdd, 5'd7, 5'd5);
        3: begin hz.id_ex_rd = 5'd0; decode(OpAdd, 5'd0, 5'd0); end
        4: decode(OpLw, 5'd3, 5'd5);
        5: decode(OpJ, 5'd5, 5'd5);
        default: begin hz.id_ex_memread = 1'b0; decode(OpAdd, 5'd5, 5'd5); end
      endcase
      @(negedge clk);
      if (outs !== exp[i]) begin
        errors++; $display("FAIL load_use[%0d]: got %b want %b", i, outs, exp[i]);
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_branch_stall();
    logic [4:0] exp [10];
    exp = '{OStall, OStall, OFlush, ONorm, OStall, OFlush, OStall, OStall, OFlush, ONorm};
    for (int i = 0; i < 10; i++) begin
      idle();
      case (i)
        0: begin hz.id_ex_memread = 1'b1; hz.id_ex_rd = 5'd5; decode(OpBeq, 5'd5, 5'd0); end
        1: begin hz.ex_mem_memread = 1'b1; hz.ex_mem_rd = 5'd5; decode(OpBeq, 5'd5, 5'd0); end
        2: begin decode(OpBeq, 5'd5, 5'd0); hz.branch_taken = 1'b1; end
        3: ;
        4: begin
          hz.ex_mem_memread = 1'b1; hz.ex_mem_rd = 5'd6;
          decode(OpBne, 5'd1, 5'd6); hz.branch_taken = 1'b1;
        end
        5: begin decode(OpBne, 5'd1, 5'd6); hz.branch_taken = 1'b1; end
        6: begin hz.id_ex_memread = 1'b1; hz.id_ex_rd = 5'd9; decode(OpJr, 5'd9, 5'd0); end
        7: begin hz.ex_mem_memread = 1'b1; hz.ex_mem_rd = 5'd9; decode(OpJr, 5'd9, 5'd0); end
        8: decode(OpJr, 5'd9, 5'd0);
        default: begin hz.ex_mem_rd = 5'd4; decode(OpBeq, 5'd4, 5'd0); end
      endcase
      @(negedge clk);
      if (outs !== exp[i]) begin
        errors++; $display("FAIL branch_stall[%0d]: got %b want %b", i, outs, exp[i]);
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_jal();
    do_reset();
    idle();
    decode(OpJal, 5'd0, 5'd0);
    @(negedge clk);
    if (outs !== OFlush) begin
      errors++; $display("FAIL jal_flush: got %b want %b", outs, OFlush);
    end
    checks++;
    tick();
`ifdef PERF_COUNTERS_EN
    if (stall_cycles !== 32'd0 || flush_count !== 32'd1) begin
      errors++; $display("FAIL jal_cnt: got stall=%0d flush=%0d want 0/1",
                         stall_cycles, flush_count);
    end
    checks++;
`endif
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      hz.ex_mem_memwrite = 1'b1;
      hz.mem_ready       = 1'b0;
      @(negedge clk);
      if (outs !== OFreeze) begin
        errors++; $display("FAIL mem_wait[%0d]: got %b want %b", i, outs, OFreeze);
      end
      checks++;
      tick();
    end
    idle();
    hz.ex_mem_memwrite = 1'b1;
    @(negedge clk);
    if (outs !== ONorm) begin
      errors++; $display("FAIL mem_wait_done: got %b want %b", outs, ONorm);
    end
    checks++;
    tick();
`ifdef PERF_COUNTERS_EN
    if (memwait_cycles !== 32'd3 || stall_cycles !== 32'd0) begin
      errors++; $display("FAIL mem_wait_cnt: got memwait=%0d stall=%0d want 3/0",
                         memwait_cycles, stall_cycles);
    end
    checks++;
`endif
    idle();
    hz.ex_mem_memread = 1'b1;
    hz.ex_mem_rd      = 5'd2;
    decode(OpAdd, 5'd3, 5'd0);
    @(negedge clk);
    if (outs !== ONorm) begin
      errors++; $display("FAIL mem_ready_same: got %b want %b", outs, ONorm);
    end
    checks++;
    tick();
    idle();
    @(negedge clk);
    if (outs !== ONorm) begin
      errors++; $display("FAIL mem_no_entry: got %b want %b", outs, ONorm);
    end
    checks++;
    tick();
  endtask

  task automatic test_stall_memwait();
    logic [4:0] exp [7];
    exp = '{OStall, OFreeze, OFreeze, OStall, OStall, OFlush, ONorm};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      idle();
      case (i)
        0: begin hz.id_ex_memread = 1'b1; hz.id_ex_rd = 5'd5; decode(OpBeq, 5'd5, 5'd0); end
        1, 2: begin
          hz.ex_mem_memread = 1'b1; hz.ex_mem_rd = 5'd5; hz.mem_ready = 1'b0;
          decode(OpBeq, 5'd5, 5'd0);
        end
        3: begin hz.ex_mem_memread = 1'b1; hz.ex_mem_rd = 5'd5; decode(OpBeq, 5'd5, 5'd0); end
        4: decode(OpBeq, 5'd5, 5'd0);
        5: begin decode(OpBeq, 5'd5, 5'd0); hz.branch_taken = 1'b1; end
        default: ;
      endcase
      @(negedge clk);
      if (outs !== exp[i]) begin
        errors++; $display("FAIL stall_memwait[%0d]: got %b want %b", i, outs, exp[i]);
      end
      checks++;
      tick();
    end
`ifdef PERF_COUNTERS_EN
    if (stall_cycles !== 32'd3 || memwait_cycles !== 32'd2 || flush_count !== 32'd1) begin
      errors++; $display("FAIL stall_memwait_cnt: got %0d/%0d/%0d want 3/2/1",
                         stall_cycles, memwait_cycles, flush_count);
    end
    checks++;
`endif
  endtask

  task automatic test_reset_midwait();
    do_reset();
    idle();
    hz.id_ex_memread = 1'b1; hz.id_ex_rd = 5'd5; decode(OpBeq, 5'd5, 5'd0);
    tick();
    idle();
    hz.ex_mem_memread = 1'b1; hz.ex_mem_rd = 5'd5; hz.mem_ready = 1'b0;
    decode(OpBeq, 5'd5, 5'd0);
    tick();
    @(negedge clk);
    if (outs !== OFreeze) begin
      errors++; $display("FAIL midwait_freeze: got %b want %b", outs, OFreeze);
    end
    checks++;
    #1 rst = 1'b0;
    #1;
    if (outs !== ORst) begin
      errors++; $display("FAIL midwait_rst: got %b want %b", outs, ORst);
    end
    checks++;
`ifdef PERF_COUNTERS_EN
    if ({stall_cycles, flush_count, memwait_cycles} !== 96'd0) begin
      errors++; $display("FAIL midwait_cnt: got %0d/%0d/%0d want 0/0/0",
                         stall_cycles, flush_count, memwait_cycles);
    end
    checks++;
`endif
    tick();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      idle();
      @(negedge clk);
      if (outs !== ONorm) begin
        errors++; $display("FAIL midwait_release[%0d]: got %b want %b", i, outs, ONorm);
      end
      checks++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_stall();
    test_jal();
    test_mem_wait();
    test_stall_memwait();
    test_reset_midwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
